// File: rtl/regfile_bank_if.sv
// regfile_bank_if: write/clear inputs and register, mask and count outputs of regfile_bank
//   master: drives wr_en, wr_addr, wr_data, clr_mask; observes regs, wr_mask, wr_count
//   slave : the register bank itself
interface regfile_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int N = 2 ** ADDR_W;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_mask;
  logic [N*DATA_W-1:0] regs;
  logic [N-1:0]      wr_mask;
  logic [15:0]       wr_count;
  modport master (output wr_en, wr_addr, wr_data, clr_mask, input regs, wr_mask, wr_count);
  modport slave  (input wr_en, wr_addr, wr_data, clr_mask, output regs, wr_mask, wr_count);
endinterface

// File: rtl/regfile_bank.sv
// regfile_bank: 2**ADDR_W x DATA_W register storage with $0 hardwired to zero, written-mask and write count
//   clk, rst (async, active-high); bus (slave): wr_en/wr_addr/wr_data/clr_mask in,
//   regs (flat view, reg k at regs[k*DATA_W +: DATA_W]), wr_mask, wr_count (saturating) out.
//   Define REG_BYPASS_EN to make regs write-first (the written value shows in the write cycle).
module regfile_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic           clk,
  input logic           rst,
  regfile_bank_if.slave bus
);
  localparam int N = 2 ** ADDR_W;
  logic wr_hit;
  assign wr_hit = bus.wr_en && (bus.wr_addr != '0);
  for (genvar g = 0; g < N; g++) begin : gen_reg
    if (g == 0) begin : gen_zero
      assign bus.regs[0 +: DATA_W] = '0;
    end else begin : gen_store
      logic [DATA_W-1:0] q;
      logic              sel;
      assign sel = wr_hit && (bus.wr_addr == ADDR_W'(g));
      always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (sel) q <= bus.wr_data;
`ifdef REG_BYPASS_EN
      assign bus.regs[g*DATA_W +: DATA_W] = sel ? bus.wr_data : q;
`else
      assign bus.regs[g*DATA_W +: DATA_W] = q;
`endif
    end
  end
  // wr_hit excludes $0, so bit 0 of the mask can never be set
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.wr_mask <= '0;
    else if (bus.clr_mask || wr_hit)
      bus.wr_mask <= (bus.clr_mask ? '0 : bus.wr_mask) | (wr_hit ? (N'(1) << bus.wr_addr) : '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.wr_count <= '0;
    else if (wr_hit && bus.wr_count != 16'hFFFF) bus.wr_count <= bus.wr_count + 16'd1;
endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed self-checking bench for regfile_bank with a write scoreboard
module tb_regfile_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_r [32];
  logic [31:0] exp_mask;
  logic [15:0] exp_cnt;
  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t sb [$];
  regfile_bank_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_bank dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] slice(input int k);
    return bus.regs[k*32 +: 32];
  endfunction
  task automatic chk_all(input string tag);
    for (int k = 0; k < 32; k++) chk($sformatf("%s_r%0d", tag, k), slice(k), exp_r[k]);
    chk({tag, "_mask"}, bus.wr_mask, exp_mask);
    chk({tag, "_cnt"}, {16'h0, bus.wr_count}, {16'h0, exp_cnt});
  endtask
  task automatic model_clear();
    for (int k = 0; k < 32; k++) exp_r[k] = '0;
    exp_mask = '0;
    exp_cnt = '0;
  endtask
  // called at posedge+1; applies one write for one cycle and returns at the next posedge+1
  task automatic wr(input int a, input logic [31:0] d, input logic c);
    wr_t e;
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'(a);
    bus.wr_data = d;
    bus.clr_mask = c;
    if (c) exp_mask = '0;
    if (a != 0) begin
      exp_r[a] = d;
      exp_mask[a] = 1'b1;
      if (exp_cnt != 16'hFFFF) exp_cnt++;
    end
    e.addr = a;
    e.data = exp_r[a];
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.clr_mask = 1'b0;
    bus.wr_addr = 'x;
    bus.wr_data = 'x;
  endtask
  task automatic drain();
    wr_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("sb_r%0d", e.addr), slice(e.addr), e.data);
    end
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.clr_mask = 1'b0;
    bus.wr_addr = 'x;
    bus.wr_data = 'x;
    model_clear();
    #1;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    wr(5, 32'hDEADBEEF, 1'b0);
    drain();
    chk_all("basic");
    chk("basic_mask_lit", bus.wr_mask, 32'h0000_0020);
    wr(9, 32'h0000_0909, 1'b0);
    drain();
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst");
    wr(0, 32'hFFFFFFFF, 1'b0);
    drain();
    chk_all("zero");
    for (int k = 1; k < 32; k++) wr(k, 32'h1000_0000 + k, 1'b0);
    drain();
    chk_all("sweep");
    chk("sweep_mask_lit", bus.wr_mask, 32'hFFFF_FFFE);
    chk("sweep_cnt_lit", {16'h0, bus.wr_count}, 32'd31);
    #3;
    chk_all("idle_x");
    @(posedge clk);
    #1;
    wr(31, 32'h12345678, 1'b1);
    drain();
    chk_all("clr_wr");
    chk("clr_wr_mask_lit", bus.wr_mask, 32'h8000_0000);
    wr(31, 32'h0BADF00D, 1'b0);
    drain();
    chk("rewrite_cnt", {16'h0, bus.wr_count}, 32'd33);
    bus.clr_mask = 1'b1;
    exp_mask = '0;
    @(posedge clk);
    #1;
    bus.clr_mask = 1'b0;
    chk_all("clr_only");
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 32'hCAFE0007;
    #1;
`ifdef REG_BYPASS_EN
    chk("bypass_r7", slice(7), 32'hCAFE0007);
`else
    chk("bypass_r7", slice(7), exp_r[7]);
`endif
    chk("bypass_r6", slice(6), exp_r[6]);
    chk("bypass_r0", slice(0), 32'h0);
    bus.wr_addr = 5'd0;
    #1;
    chk("bypass_zero", slice(0), 32'h0);
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;
    wr(7, 32'hCAFE0007, 1'b0);
    drain();
    chk_all("final");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
